// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and default width for the multiply/divide sequencer
// Contents:
//   OP_MULT / OP_DIV      operation select encodings
//   state_t               3-bit FSM state encoding (IDLE, CHECK, RUN, FIX, DONE)
//   DEF_WIDTH             default operand width
package muldiv_pkg;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RUN   = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed multiply (shift-add) / divide (restoring) unit with Hi/Lo results
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset, clears all state
//   start       request, sampled in IDLE or DONE
//   op          0 = mult, 1 = div, latched with start
//   a, b        operands (multiplicand/dividend, multiplier/divisor), latched with start
//   busy        high in CHECK, RUN, FIX
//   done        one-cycle completion pulse
//   div_zero    high with done for a divide by zero
//   hilo_write  one-cycle pulse with done on successful completion
//   hi, lo      registered results (mult: product halves; div: remainder / quotient)
// Build option: MULTDIV_EARLY_EXIT_EN ends a multiply once the remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hilo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
`ifdef MULTDIV_EARLY_EXIT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif
  state_t state, state_n;
  logic op_r, neg_q, neg_r;
  logic [WIDTH-1:0] a_r, b_r, a_mag, b_mag, mplier, quo_f, rem_f;
  logic [2*WIDTH-1:0] acc, mcand, acc_mul, prod_f;
  logic [WIDTH:0] rem_sh, rem_diff;
  logic [CNT_W-1:0] cnt;
  logic take, dz_hit, run_last, mul_zero;
  // For mult, acc holds the product and mcand the shifting multiplicand.
  // For div, acc[WIDTH-1:0] is the remainder, mplier doubles as the dividend/quotient
  // shift register and mcand[WIDTH-1:0] holds the divisor magnitude.
  always_comb begin
    a_mag    = a_r[WIDTH-1] ? -a_r : a_r;
    b_mag    = b_r[WIDTH-1] ? -b_r : b_r;
    acc_mul  = mplier[0] ? acc + mcand : acc;
    rem_sh   = {acc[WIDTH-1:0], mplier[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mcand[WIDTH-1:0]};
    take     = !rem_diff[WIDTH];
    prod_f   = neg_q ? -acc : acc;
    quo_f    = neg_q ? -mplier : mplier;
    rem_f    = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    dz_hit   = op_r == OP_DIV && b_r == '0;
    mul_zero = EARLY && op_r == OP_MULT && b_mag == '0;
    run_last = cnt == CNT_W'(1) || (EARLY && op_r == OP_MULT && mplier[WIDTH-1:1] == '0);
  end
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = start ? CHECK : IDLE;
      CHECK:   state_n = dz_hit ? DONE : mul_zero ? FIX : RUN;
      RUN:     state_n = run_last ? FIX : RUN;
      FIX:     state_n = DONE;
      DONE:    state_n = start ? CHECK : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      hilo_write <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      op_r       <= OP_MULT;
      a_r        <= '0;
      b_r        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
    end else begin
      state      <= state_n;
      busy       <= state_n == CHECK || state_n == RUN || state_n == FIX;
      done       <= state_n == DONE;
      div_zero   <= state == CHECK && dz_hit;
      hilo_write <= state == FIX;
      if (start && (state == IDLE || state == DONE)) begin
        op_r <= op;
        a_r  <= a;
        b_r  <= b;
      end
      case (state)
        CHECK: begin
          neg_q  <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
          neg_r  <= a_r[WIDTH-1];
          cnt    <= CNT_W'(WIDTH);
          acc    <= '0;
          mplier <= op_r == OP_DIV ? a_mag : b_mag;
          mcand  <= {{WIDTH{1'b0}}, op_r == OP_DIV ? b_mag : a_mag};
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (op_r == OP_MULT) begin
            acc    <= acc_mul;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            acc    <= {{WIDTH{1'b0}}, take ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]};
            mplier <= {mplier[WIDTH-2:0], take};
          end
        end
        FIX: begin
          hi <= op_r == OP_DIV ? rem_f : prod_f[2*WIDTH-1:WIDTH];
          lo <= op_r == OP_DIV ? quo_f : prod_f[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle signed multiply/divide unit with its own sequencing FSM, serving the MIPS `mult`/`div` instructions (funct 0x18/0x1a).
- The main control unit pulses `start` with the operands from registers A/B, waits on `busy`/`done`, then continues.
- Results go to the Hi/Lo registers through `hilo_write`.
- Division by zero is reported to the exception path rather than written.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  request; sampled in IDLE or DONE only.
- op  in  1  0 = mult, 1 = div; latched with start.
- a  in  WIDTH  rs operand (multiplicand / dividend); latched with start.
- b  in  WIDTH  rt operand (multiplier / divisor); latched with start.
- busy  out  1  high in CHECK, RUN, FIX.
- done  out  1  one-cycle pulse in DONE.
- div_zero  out  1  high with done when op=div and b=0.
- hilo_write  out  1  one-cycle pulse with done on successful completion.
- hi  out  WIDTH  registered Hi result.
- lo  out  WIDTH  registered Lo result.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - busy, done, div_zero, hilo_write, hi, lo and all internal registers go to 0.
  - Applies at any point, including mid-RUN; the partial result is discarded and hi/lo return to 0.
- States: IDLE, CHECK, RUN, FIX, DONE.
- IDLE:
  - If start=1, latch op, a and b, then go to CHECK. Otherwise stay.
- CHECK (1 cycle):
  - Form magnitudes |a| and |b|.
  - Record sign flags: result sign = a[31]^b[31]; remainder sign = a[31].
  - If op=div and b=0, go to DONE with div_zero set.
  - Otherwise load CNT = WIDTH and go to RUN.
- RUN, mult (unsigned shift-add on magnitudes, one iteration per cycle):
  - acc += mcand when mplier[0]=1.
  - mcand <<= 1 (2*WIDTH-bit register).
  - mplier >>= 1.
  - CNT -= 1.
- RUN, div (restoring, one iteration per cycle):
  - {rem, quo} <<= 1.
  - If rem >= |b|: rem -= |b| and set quo[0]=1.
  - CNT -= 1.
- RUN exit: leave to FIX when CNT reaches 0, giving exactly WIDTH RUN cycles.
- FIX (1 cycle):
  - Mult: negate the 64-bit product (two's complement) if the sign flag is set.
  - Div: negate the quotient if a[31]^b[31]; negate the remainder if a[31].
- DONE (1 cycle):
  - done=1.
  - If not div_zero: hilo_write=1 and update hi/lo.
    - Mult: hi = product[63:32], lo = product[31:0].
    - Div: lo = quotient, hi = remainder.
  - div_zero case: hi/lo are unchanged and hilo_write=0.
  - Next state: CHECK if start=1 (back-to-back request), else IDLE.
- hi/lo hold their value until the next successful completion.
- Latency, with start sampled at the end of cycle 0:
  - CHECK in cycle 1, RUN in cycles 2..33, FIX in cycle 34, done in cycle 35.
  - Divide by zero: done in cycle 2.
- start while busy=1 is ignored (no queuing).
- op, a and b are don't-care outside the start cycle.
- Division truncates toward zero; the remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0, no flag.
- Overflow is never signalled; the 64-bit product is always exact.

Optional Feature:
- MULTDIV_EARLY_EXIT_EN defined:
  - Mult leaves RUN for FIX at the end of any iteration that leaves mplier = 0.
  - If |b| = 0 at CHECK, the FSM goes straight from CHECK to FIX.
  - Mult RUN length = index of the highest set bit of |b| + 1.
  - Div is unaffected; results are identical.
- Undefined: fixed WIDTH RUN cycles for both operations.

Decomposition:
- Package muldiv_pkg holds:
  - Op encodings OP_MULT=1'b0 and OP_DIV=1'b1.
  - The 3-bit state encodings: IDLE=0, CHECK=1, RUN=2, FIX=3, DONE=4.
  - The default width constant.
- No sub-module.
  - The FSM and both iteration datapaths share the acc/rem register, the counter and the sign flags in one module.
  - The mult and div arithmetic are separate combinational blocks selected by op.

Test Plan:
- mult a=7, b=0xFFFFFFFD (-3) -> done in cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFEB, hilo_write=1, busy high in cycles 1-34.
- mult a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1. With MULTDIV_EARLY_EXIT_EN, mult a=5, b=3 -> done in cycle 5.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- div a=10, b=0 -> done and div_zero in cycle 2, hilo_write=0, hi/lo keep their prior values.
- start pulsed in cycle 10 of an active op -> ignored. start held high in the DONE cycle -> CHECK next cycle, second result correct.
- reset=0 in cycle 20 of RUN -> busy, hi and lo go to 0 immediately with no done pulse; after reset=1 a new mult completes normally.
